// File: rtl/vov_frame_collector.sv
// Packs N consecutive K-bit vote-vector words into frames with a popcount and
// queues them in a show-ahead FIFO drained over a valid/ready handshake.
module vov_frame_collector #(
    parameter int unsigned K     = 4,
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [K-1:0]               vov_in,
    input  logic                       vov_vld,
    input  logic                       flush,
    output logic [N*K-1:0]             frm_data,
    output logic [$clog2(N*K+1)-1:0]   frm_ones,
    output logic                       frm_valid,
    input  logic                       frm_ready,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       ovf,
    input  logic                       clr_ovf
);

    localparam int unsigned FW = N * K;
    localparam int unsigned OW = $clog2(N * K + 1);
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [CW-1:0] cnt;
    logic [FW-1:0] asm_data;
    logic [OW-1:0] asm_ones;
    logic [OW-1:0] word_ones;
    logic [FW-1:0] frame_next;
    logic [OW-1:0] ones_next;

    logic [FW-1:0] mem_data [DEPTH];
    logic [OW-1:0] mem_ones [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic complete;
    logic pop;
    logic push_ok;
    logic ovf_set;

    always_comb begin
        word_ones = '0;
        for (int unsigned i = 0; i < K; i++) begin
            word_ones = word_ones + OW'(vov_in[i]);
        end
    end

    // Slots above cnt are always zero, so merging the incoming word is enough.
    always_comb begin
        frame_next = asm_data;
        frame_next[cnt*K +: K] = vov_in;
        ones_next = asm_ones + word_ones;
    end

    // A word arriving with flush restarts assembly, so it can never complete a frame.
    assign complete  = vov_vld && !flush && (cnt == CNT_LAST);
    assign frm_valid = (fill_level != '0);
    assign pop       = frm_valid && frm_ready;
    assign push_ok   = complete && ((fill_level < LVL_FULL) || pop);
    assign ovf_set   = complete && !push_ok;

    assign frm_data = frm_valid ? mem_data[rd_ptr] : '0;
    assign frm_ones = frm_valid ? mem_ones[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            asm_data <= '0;
            asm_ones <= '0;
        end else if (flush) begin
            if (vov_vld) begin
                cnt      <= CW'(1);
                asm_data <= FW'(vov_in);
                asm_ones <= word_ones;
            end else begin
                cnt      <= '0;
                asm_data <= '0;
                asm_ones <= '0;
            end
        end else if (vov_vld) begin
            if (cnt == CNT_LAST) begin
                cnt      <= '0;
                asm_data <= '0;
                asm_ones <= '0;
            end else begin
                cnt      <= cnt + CW'(1);
                asm_data <= frame_next;
                asm_ones <= ones_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= frame_next;
            mem_ones[wr_ptr] <= ones_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            ovf        <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   fill_level <= fill_level + LW'(1);
                2'b01:   fill_level <= fill_level - LW'(1);
                default: fill_level <= fill_level;
            endcase
            if (ovf_set)      ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vov_frame_collector.sv
// Directed self-checking bench for vov_frame_collector at K=4, N=4, DEPTH=4.
module tb_vov_frame_collector;

    logic        clk;
    logic        rst_n;
    logic [3:0]  vov_in;
    logic        vov_vld;
    logic        flush;
    logic [15:0] frm_data;
    logic [4:0]  frm_ones;
    logic        frm_valid;
    logic        frm_ready;
    logic [2:0]  fill_level;
    logic        ovf;
    logic        clr_ovf;

    int checks = 0;
    int errors = 0;

    vov_frame_collector #(.K(4), .N(4), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vov_in     (vov_in),
        .vov_vld    (vov_vld),
        .flush      (flush),
        .frm_data   (frm_data),
        .frm_ones   (frm_ones),
        .frm_valid  (frm_valid),
        .frm_ready  (frm_ready),
        .fill_level (fill_level),
        .ovf        (ovf),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [3:0] w);
        vov_in  = w;
        vov_vld = 1'b1;
        step();
        vov_vld = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] f);
        for (int i = 0; i < 4; i++) send_word(f[i*4 +: 4]);
    endtask

    task automatic pop_one;
        frm_ready = 1'b1;
        step();
        frm_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; vov_in = '0; vov_vld = 0; flush = 0; frm_ready = 0; clr_ovf = 0;
        #1;
        checks++;
        if (frm_valid !== 1'b0 || frm_data !== 16'h0 || frm_ones !== 5'd0 ||
            fill_level !== 3'd0 || ovf !== 1'b0) begin
            $display("FAIL reset_outputs got v=%b d=%h o=%0d f=%0d ovf=%b want all 0",
                     frm_valid, frm_data, frm_ones, fill_level, ovf);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic;
        send_frame(16'hF321);
        checks++;
        if (frm_valid !== 1'b1 || frm_data !== 16'hF321 || frm_ones !== 5'd8) begin
            $display("FAIL basic_frame got v=%b d=%h o=%0d want v=1 d=f321 o=8",
                     frm_valid, frm_data, frm_ones);
            errors++;
        end
        pop_one();
        checks++;
        if (frm_valid !== 1'b0 || frm_data !== 16'h0 || frm_ones !== 5'd0) begin
            $display("FAIL basic_empty got v=%b d=%h o=%0d want 0 0 0",
                     frm_valid, frm_data, frm_ones);
            errors++;
        end
    endtask

    task automatic test_overflow;
        logic [15:0] exp_d [4];
        logic [4:0]  exp_o [4];
        exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h7777};
        exp_o = '{5'd4, 5'd4, 5'd8, 5'd12};
        for (int i = 0; i < 4; i++) send_frame(exp_d[i]);
        checks++;
        if (fill_level !== 3'd4 || ovf !== 1'b0) begin
            $display("FAIL ovf_full got f=%0d ovf=%b want f=4 ovf=0", fill_level, ovf);
            errors++;
        end
        send_frame(16'hFFFF);
        checks++;
        if (fill_level !== 3'd4 || ovf !== 1'b1) begin
            $display("FAIL ovf_drop got f=%0d ovf=%b want f=4 ovf=1", fill_level, ovf);
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (frm_valid !== 1'b1 || frm_data !== exp_d[i] || frm_ones !== exp_o[i]) begin
                $display("FAIL ovf_drain%0d got v=%b d=%h o=%0d want v=1 d=%h o=%0d",
                         i, frm_valid, frm_data, frm_ones, exp_d[i], exp_o[i]);
                errors++;
            end
            pop_one();
        end
        checks++;
        if (frm_valid !== 1'b0 || frm_data !== 16'h0 || fill_level !== 3'd0) begin
            $display("FAIL ovf_empty got v=%b d=%h f=%0d want 0 0 0",
                     frm_valid, frm_data, fill_level);
            errors++;
        end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            $display("FAIL ovf_clear got %b want 0", ovf);
            errors++;
        end
    endtask

    task automatic test_full_pop;
        logic [15:0] exp_d [4];
        logic [4:0]  exp_o [4];
        exp_d = '{16'h0002, 16'h0003, 16'h0004, 16'h8000};
        exp_o = '{5'd1, 5'd2, 5'd1, 5'd1};
        send_frame(16'h0001);
        send_frame(16'h0002);
        send_frame(16'h0003);
        send_frame(16'h0004);
        send_word(4'h0);
        send_word(4'h0);
        send_word(4'h0);
        frm_ready = 1'b1;
        send_word(4'h8);
        frm_ready = 1'b0;
        checks++;
        if (fill_level !== 3'd4 || ovf !== 1'b0) begin
            $display("FAIL fullpop_level got f=%0d ovf=%b want f=4 ovf=0", fill_level, ovf);
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (frm_valid !== 1'b1 || frm_data !== exp_d[i] || frm_ones !== exp_o[i]) begin
                $display("FAIL fullpop_drain%0d got v=%b d=%h o=%0d want v=1 d=%h o=%0d",
                         i, frm_valid, frm_data, frm_ones, exp_d[i], exp_o[i]);
                errors++;
            end
            pop_one();
        end
    endtask

    task automatic test_flush;
        send_word(4'h1);
        send_word(4'h2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        send_frame(16'hDCBA);
        checks++;
        if (frm_valid !== 1'b1 || frm_data !== 16'hDCBA || frm_ones !== 5'd10) begin
            $display("FAIL flush_plain got v=%b d=%h o=%0d want v=1 d=dcba o=10",
                     frm_valid, frm_data, frm_ones);
            errors++;
        end
        pop_one();
        // three words leave the counter at its last slot when flush+vld arrives
        send_word(4'h3);
        send_word(4'h4);
        send_word(4'h5);
        flush = 1'b1;
        send_word(4'hA);
        flush = 1'b0;
        checks++;
        if (frm_valid !== 1'b0 || fill_level !== 3'd0) begin
            $display("FAIL flush_nocomplete got v=%b f=%0d want v=0 f=0", frm_valid, fill_level);
            errors++;
        end
        send_word(4'hB);
        send_word(4'hC);
        send_word(4'hD);
        checks++;
        if (frm_valid !== 1'b1 || frm_data !== 16'hDCBA || frm_ones !== 5'd10) begin
            $display("FAIL flush_coincident got v=%b d=%h o=%0d want v=1 d=dcba o=10",
                     frm_valid, frm_data, frm_ones);
            errors++;
        end
        pop_one();
    endtask

    task automatic test_reset_mid;
        send_frame(16'h1234);
        send_frame(16'h5678);
        send_word(4'h9);
        send_word(4'h9);
        send_word(4'h9);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (frm_valid !== 1'b0 || frm_data !== 16'h0 || frm_ones !== 5'd0 ||
            fill_level !== 3'd0 || ovf !== 1'b0) begin
            $display("FAIL midreset_outputs got v=%b d=%h o=%0d f=%0d ovf=%b want all 0",
                     frm_valid, frm_data, frm_ones, fill_level, ovf);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send_frame(16'h4321);
        checks++;
        if (frm_valid !== 1'b1 || frm_data !== 16'h4321 || frm_ones !== 5'd5 ||
            fill_level !== 3'd1) begin
            $display("FAIL midreset_frame got v=%b d=%h o=%0d f=%0d want v=1 d=4321 o=5 f=1",
                     frm_valid, frm_data, frm_ones, fill_level);
            errors++;
        end
        pop_one();
    endtask

    task automatic test_ovf_clr;
        for (int i = 0; i < 5; i++) send_frame(16'h00F0);
        checks++;
        if (ovf !== 1'b1) begin
            $display("FAIL clr_setup got ovf=%b want 1", ovf);
            errors++;
        end
        send_word(4'h1);
        send_word(4'h1);
        send_word(4'h1);
        clr_ovf = 1'b1;
        send_word(4'h1);
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b1 || fill_level !== 3'd4) begin
            $display("FAIL clr_setwins got ovf=%b f=%0d want ovf=1 f=4", ovf, fill_level);
            errors++;
        end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            $display("FAIL clr_alone got ovf=%b want 0", ovf);
            errors++;
        end
        for (int i = 0; i < 4; i++) pop_one();
        checks++;
        if (fill_level !== 3'd0 || frm_valid !== 1'b0) begin
            $display("FAIL clr_drain got f=%0d v=%b want 0 0", fill_level, frm_valid);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_flush();
        test_reset_mid();
        test_ovf_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
